// File: rtl/mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
// Shared types and helpers for the round-robin packet-locking mux arbiter.
//   arb_state_t : arbiter FSM states (idle / locked to one packet owner)
//   rr_pick     : behavioural round-robin winner selection, scanning
//                 ptr, ptr+1, ... modulo n_req, for up to MAX_REQ requesters
// ---------------------------------------------------------------------------
package mux_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int MAX_REQ = 32;
  localparam int PICK_W  = 5;

  // Returns the first requesting index at or after ptr, wrapping at n_req.
  // When nothing is requesting the pointer itself is returned.
  function automatic logic [PICK_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [PICK_W-1:0]  ptr,
    input int                 n_req
  );
    logic [PICK_W-1:0] winner;
    logic [PICK_W-1:0] cand;
    winner = ptr;
    // Scan from the far end back toward ptr so the closest hit wins last.
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n_req) begin
        cand = PICK_W'((int'(ptr) + k) % n_req);
        if (req[cand]) winner = cand;
      end
    end
    return winner;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin priority picker: rotates the request vector so
// that index ptr sits at bit 0, finds the first set bit, then adds ptr back
// (modulo N_REQ) to recover the absolute winner index.
// Ports:
//   req  in  N_REQ   request vector
//   ptr  in  PTR_W   highest-priority index (must be < N_REQ)
//   any  out 1       at least one request is set
//   idx  out PTR_W   winning index (only meaningful when any=1)
// ---------------------------------------------------------------------------
module rr_priority_pick
  import mux_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             any,
  output logic [PTR_W-1:0] idx
);

  localparam logic [PTR_W:0] N_WIDE = (PTR_W + 1)'(N_REQ);

  logic [N_REQ-1:0] rotated;
  logic [PTR_W-1:0] offset;
  logic [PTR_W:0]   sum;

  assign any = |req;

  // Shifting the doubled vector right by ptr is a rotate; the cast keeps
  // the low N_REQ bits, which hold req[ptr], req[ptr+1], ... wrapped.
  assign rotated = N_REQ'({req, req} >> ptr);

  // Find-first-set on the rotated vector: lowest set bit is the offset of
  // the winner from ptr.
  always_comb begin
    offset = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rotated[j]) offset = PTR_W'(j);
    end
  end

  // Undo the rotation with a modulo-N_REQ add that also works when N_REQ
  // is not a power of two.
  always_comb begin
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= N_WIDE) sum = sum - N_WIDE;
    idx = sum[PTR_W-1:0];
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter
// Round-robin, packet-locking arbiter driving the select of an N:1 beat mux.
// A requester is granted in IDLE and keeps the grant until its last beat is
// accepted downstream; priority then moves to the next index.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   req_valid/last      per-requester beat valid and end-of-packet
//   req_data            flattened beats, requester i at [i*DATA_W +: DATA_W]
//   req_ready           per-requester accept (only the owner can be ready)
//   out_valid/data/last muxed beat toward the single consumer
//   out_ready           consumer accept
//   grant               one-hot current owner, zero when idle
//   busy                high while a packet owns the channel
// ---------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
);

  import mux_arb_pkg::*;

  localparam int               PTR_W     = $clog2(N_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT_0 = N_REQ'(1);

  arb_state_t       state, state_next;
  logic [N_REQ-1:0] grant_next;
  logic [PTR_W-1:0] ptr, ptr_next;
  logic [PTR_W-1:0] owner_idx;
  logic             pick_any;
  logic [PTR_W-1:0] pick_idx;
  logic             last_accept;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Binary index of the current owner, needed to advance the pointer past it.
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) owner_idx = PTR_W'(i);
    end
  end

  // Output mux selected purely by the registered grant; with no grant every
  // output stays zero, so an async reset clears them without a clock edge.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i] && state == ARB_LOCKED) begin
        out_valid    = req_valid[i];
        out_data     = req_data[i*DATA_W +: DATA_W];
        out_last     = req_last[i];
        req_ready[i] = out_ready;
      end
    end
  end

  assign last_accept = out_valid && out_ready && out_last;
  assign busy        = (state == ARB_LOCKED);

  // Next-state logic: arbitrate only in IDLE, release only on an accepted
  // last beat. Requests arriving alongside that last beat wait for the
  // following IDLE cycle.
  always_comb begin
    state_next = state;
    grant_next = grant;
    ptr_next   = ptr;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_next = ARB_LOCKED;
          grant_next = ONE_HOT_0 << pick_idx;
        end
      end
      ARB_LOCKED: begin
        if (last_accept) begin
          state_next = ARB_IDLE;
          grant_next = '0;
          ptr_next   = (owner_idx == LAST_IDX) ? '0 : owner_idx + PTR_W'(1);
        end
      end
      default: begin
        state_next = ARB_IDLE;
        grant_next = '0;
      end
    endcase
  end

  // State, grant and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      ptr   <= ptr_next;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_arbiter
// Self-checking bench for mux_rr_arbiter (N_REQ=4, DATA_W=8). A reference
// model tracks only the current owner (or none) and the priority index as
// integers and derives every expected output from them.
// ---------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int VW = 2*N + 3 + DW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            out_ready;
  logic [N-1:0]    grant;
  logic            busy;
  logic [VW-1:0]   act_vec;

  int checks  = 0;
  int errors  = 0;
  int m_owner = -1;
  int m_ptr   = 0;

  mux_rr_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign act_vec = {busy, grant, req_ready, out_valid, out_last, out_data};

  // Expected outputs from the model owner and the current inputs.
  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0]  g, rr;
    logic          ov, ol;
    logic [DW-1:0] od;
    g = '0; rr = '0; ov = 1'b0; ol = 1'b0; od = '0;
    if (m_owner >= 0) begin
      g[m_owner]  = 1'b1;
      rr[m_owner] = out_ready;
      ov = req_valid[m_owner];
      ol = req_last[m_owner];
      od = req_data[m_owner*DW +: DW];
    end
    return {(m_owner >= 0), g, rr, ov, ol, od};
  endfunction

  // Advance the model across one rising edge, then settle 1 time unit after.
  task automatic step();
    int nxt_owner;
    int nxt_ptr;
    nxt_owner = m_owner;
    nxt_ptr   = m_ptr;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (req_valid[(m_ptr + k) % N]) begin
          nxt_owner = (m_ptr + k) % N;
          break;
        end
      end
    end else if (req_valid[m_owner] && out_ready && req_last[m_owner]) begin
      nxt_owner = -1;
      nxt_ptr   = (m_owner + 1) % N;
    end
    @(posedge clk);
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
    end else begin
      m_owner = nxt_owner;
      m_ptr   = nxt_ptr;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req_valid = N'($urandom);
      req_last  = N'($urandom);
      req_data  = $urandom;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (act_vec !== '0)
        $display("[TB] FAIL reset_outputs: got %h expected %h", act_vec, {VW{1'b0}});
      if (act_vec !== '0) errors++;
      step();
    end
    req_valid = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || grant !== '0 || act_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL reset_idle: got %h expected %h", act_vec, exp_vec());
      end
      step();
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_seq [10] = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000,
                                   4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    req_valid = '1;
    req_last  = '1;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      req_data = $urandom;
      @(negedge clk);
      checks++;
      if (grant !== exp_seq[c]) begin
        errors++;
        $display("[TB] FAIL contention_grant[%0d]: got %b expected %b", c, grant, exp_seq[c]);
      end
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL contention_outputs[%0d]: got %h expected %h", c, act_vec, exp_vec());
      end
      step();
    end
    req_valid = '0;
  endtask

  task automatic test_wrap_skip();
    logic [N-1:0] valid_seq [7] = '{4'b0100, 4'b0100, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0000};
    logic [N-1:0] exp_seq   [7] = '{4'b0000, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      req_valid = valid_seq[c];
      req_last  = valid_seq[c];
      req_data  = $urandom;
      @(negedge clk);
      checks++;
      if (grant !== exp_seq[c]) begin
        errors++;
        $display("[TB] FAIL wrap_skip_grant[%0d]: got %b expected %b", c, grant, exp_seq[c]);
      end
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL wrap_skip_outputs[%0d]: got %h expected %h", c, act_vec, exp_vec());
      end
      step();
    end
  endtask

  task automatic test_packet_lock();
    logic [DW-1:0] beats    [3] = '{8'hA1, 8'hA2, 8'hA3};
    logic [N-1:0]  exp_seq  [6] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
    logic [DW-1:0] got [$];
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      req_data = $urandom;
      req_data[0*DW +: DW] = 8'h55;
      req_last[0] = 1'b1;
      req_last[3:2] = 2'b00;
      req_valid[3:2] = 2'b00;
      req_valid[0] = (c != 0);
      req_valid[1] = (c <= 3);
      req_data[1*DW +: DW] = (c >= 1 && c <= 3) ? beats[c-1] : 8'h00;
      req_last[1] = (c == 3);
      @(negedge clk);
      if (out_valid && out_ready && grant[1]) got.push_back(out_data);
      checks++;
      if (grant !== exp_seq[c]) begin
        errors++;
        $display("[TB] FAIL lock_grant[%0d]: got %b expected %b", c, grant, exp_seq[c]);
      end
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL lock_outputs[%0d]: got %h expected %h", c, act_vec, exp_vec());
      end
      step();
    end
    checks++;
    if (got.size() != 3 || got[0] !== 8'hA1 || got[1] !== 8'hA2 || got[2] !== 8'hA3) begin
      errors++;
      $display("[TB] FAIL lock_beats: got %p expected A1 A2 A3", got);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] beats   [3] = '{8'hB1, 8'hB2, 8'hB3};
    logic          bp_v    [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic          bp_r    [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [DW-1:0] got [$];
    int b = 0;
    for (int c = 0; c < 8; c++) begin
      req_data  = $urandom;
      req_valid = (c >= 1 && c <= 6) ? N'($urandom) : '0;
      req_last  = N'($urandom);
      req_valid[3] = bp_v[c];
      req_data[3*DW +: DW] = (b < 3) ? beats[b] : 8'h00;
      req_last[3] = (b == 2);
      out_ready = bp_r[c];
      @(negedge clk);
      if (out_valid && out_ready) got.push_back(out_data);
      checks++;
      if (grant !== ((c >= 1 && c <= 6) ? 4'b1000 : 4'b0000)) begin
        errors++;
        $display("[TB] FAIL bp_grant[%0d]: got %b", c, grant);
      end
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL bp_outputs[%0d]: got %h expected %h", c, act_vec, exp_vec());
      end
      if (m_owner == 3 && bp_v[c] && bp_r[c]) b++;
      step();
    end
    checks++;
    if (got.size() != 3 || got[0] !== 8'hB1 || got[1] !== 8'hB2 || got[2] !== 8'hB3) begin
      errors++;
      $display("[TB] FAIL bp_beats: got %p expected B1 B2 B3", got);
    end
    req_valid = '0;
    out_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [N-1:0]  valid_seq [4] = '{4'b0010, 4'b0010, 4'b0100, 4'b0100};
    logic [N-1:0]  last_seq  [4] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};
    logic [DW-1:0] data_seq  [4] = '{8'h11, 8'h11, 8'hC1, 8'hC1};
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      req_valid = valid_seq[c];
      req_last  = last_seq[c];
      req_data  = $urandom;
      req_data[1*DW +: DW] = data_seq[c];
      req_data[2*DW +: DW] = data_seq[c];
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL areset_pre[%0d]: got %h expected %h", c, act_vec, exp_vec());
      end
      step();
    end
    req_data[2*DW +: DW] = 8'hC2;
    #1;
    checks++;
    if (grant !== 4'b0100 || out_data !== 8'hC2 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL areset_beat2: got grant %b data %h valid %b", grant, out_data, out_valid);
    end
    #1;
    rst_n = 1'b0;
    m_owner = -1;
    m_ptr = 0;
    #1;
    checks++;
    if (act_vec !== '0) begin
      errors++;
      $display("[TB] FAIL areset_immediate: got %h expected %h", act_vec, {VW{1'b0}});
    end
    step();
    rst_n = 1'b1;
    req_valid = 4'b0111;
    req_last  = 4'b0111;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (grant !== ((c == 1) ? 4'b0001 : 4'b0000) || act_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL areset_restart[%0d]: got %h expected %h", c, act_vec, exp_vec());
      end
      step();
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_last[i]  = ($urandom_range(0, 2) == 0);
      end
      req_data  = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL random[%0d]: got %h expected %h", c, act_vec, exp_vec());
      end
      step();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_contention();
    test_wrap_skip();
    test_packet_lock();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
